// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants for the nibble-serial adder: FSM states,
// nibble size and the derived nibble-count / index-width helpers.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  function automatic int nib_cnt(input int width);
    return width / NIBBLE;
  endfunction

  function automatic int idx_w(input int width);
    return $clog2(width / NIBBLE);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_adder.sv
// nibble_adder: 4-bit ripple of full-adder cells, purely
// combinational; shared by every nibble step of the serial adder.
module nibble_adder
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] sum,
  output logic              cout
);

  logic [NIBBLE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder: a+b+cin over WIDTH/4 cycles, LSB nibble first.
// Optional SUBTRACT_EN adds a sub port computing a + ~b + 1.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = nib_cnt(WIDTH);
  localparam int IW = idx_w(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [IW-1:0]    idx;

  logic [WIDTH-1:0]  b_in;
  logic              c_in;
  logic [NIBBLE-1:0] na;
  logic [NIBBLE-1:0] nb;
  logic [NIBBLE-1:0] ns;
  logic              nc;

`ifdef SUBTRACT_EN
  // Two's-complement subtract: invert B and force carry-in high.
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  assign na = ra[idx*NIBBLE +: NIBBLE];
  assign nb = rb[idx*NIBBLE +: NIBBLE];

  nibble_adder u_add (
    .a    (na),
    .b    (nb),
    .cin  (carry),
    .sum  (ns),
    .cout (nc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ra     <= '0;
      rb     <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      idx    <= '0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (start) begin
            state  <= S_RUN;
            ra     <= a;
            rb     <= b_in;
            carry  <= c_in;
            sum_q  <= '0;
            cout_q <= 1'b0;
            idx    <= '0;
          end
        end
        (state == S_RUN): begin
          sum_q[idx*NIBBLE +: NIBBLE] <= ns;
          carry <= nc;
          idx   <= idx + IW'(1);
          if (idx == LAST) begin
            state  <= S_DONE;
            cout_q <= nc;
          end
        end
        (state == S_DONE): state <= S_IDLE;
        default:           state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN) || (state == S_DONE);
  assign done = (state == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: arithmetic reference model
// checked every cycle, plus directed literal cases.
module tb_nibble_serial_adder_ctrl;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         cout;
  logic [W-1:0] sum;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SUBTRACT_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: ph counts nibbles since accept; sum is the true result
  // masked to the nibbles already produced.
  int           ph = 0;
  logic [W:0]   res = '0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         use_sub;
  bit           en = 0;

  always @(posedge clk) begin
    use_sub = 1'b0;
`ifdef SUBTRACT_EN
    use_sub = sub;
`endif
    if (rst) begin
      ph = 0;
      m_sum = '0;
      m_cout = 1'b0;
    end else if (ph == 0) begin
      if (start) begin
        if (use_sub)
          res = (W+1)'(a) + (W+1)'(~b) + (W+1)'(1);
        else
          res = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
        m_sum = '0;
        m_cout = 1'b0;
        ph = 1;
      end
    end else if (ph <= N) begin
      m_sum = res[W-1:0] & W'((64'd1 << (4 * ph)) - 64'd1);
      if (ph == N) m_cout = res[W];
      ph++;
    end else begin
      ph = 0;
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("m_busy", 32'(busy), 32'(ph != 0));
      chk("m_done", 32'(done), 32'(ph == N + 1));
      chk("m_sum", 32'(sum), 32'(m_sum));
      if (ph == 0 || ph == N + 1)
        chk("m_cout", 32'(cout), 32'(m_cout));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("idle_timeout", 32'(1), 32'(0));
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic ic,
                       input logic is, input logic [W-1:0] es,
                       input logic ec);
    int n;
    wait_idle();
    @(posedge clk); #1;
    a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    cin = 1'($urandom); sub = 1'($urandom);
    chk({nm, "_busy"}, 32'(busy), 32'(1));
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(N));
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
    @(posedge clk); #1;
    chk({nm, "_done_off"}, 32'(done), 32'(0));
    chk({nm, "_hold"}, 32'(sum), 32'(es));
  endtask

  int dn;
  int nr;
  int wide;
  int tr[$];
  logic prev;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    rst = 1'b0;
    en = 1;

    do_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("ripple_hold_sum", 32'(sum), 32'(16'h0000));
    chk("ripple_hold_cout", 32'(cout), 32'(1));
    do_op("wrap", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);

    // start during RUN must be ignored
    wait_idle();
    @(posedge clk); #1;
    a = 16'h0000; b = 16'h0000; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 16'hAAAA;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    dn = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) begin
        dn++;
        chk("ign_sum", 32'(sum), 32'(16'h0001));
      end
    end
    chk("ign_pulses", 32'(dn), 32'(1));
    chk("ign_final", 32'(sum), 32'(16'h0001));

    // reset on the second RUN edge aborts the operation
    wait_idle();
    @(posedge clk); #1;
    a = 16'h00F0; b = 16'h0010; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_sum", 32'(sum), 32'(0));
    chk("abort_cout", 32'(cout), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    dn = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'(0));
    do_op("after_abort", 16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0);

`ifdef SUBTRACT_EN
    do_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    do_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
`endif

    // back-to-back with start held high
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1;
    prev = 1'b0;
    wide = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (done && prev) wide++;
      if (done && !prev) tr.push_back(c);
      prev = done;
    end
    start = 1'b0;
    nr = tr.size();
    chk("b2b_pulses", 32'(nr >= 5), 32'(1));
    for (int i = 1; i < nr; i++)
      chk("b2b_gap", 32'(tr[i] - tr[i-1]), 32'(N + 2));
    chk("b2b_wide", 32'(wide), 32'(0));

    // randomized traffic with occasional resets
    wait_idle();
    repeat (400) begin
      @(posedge clk); #1;
      start = ($urandom % 3) == 0;
      a = W'($urandom); b = W'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      rst = ($urandom % 50) == 0;
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (N + 3) @(posedge clk);
    #1;
    chk("end_idle", 32'(busy), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to add the presented operands.
REQ-005 a  input  WIDTH  operand A.
REQ-006 b  input  WIDTH  operand B.
REQ-007 cin  input  1  carry-in to nibble 0.
REQ-008 sub  input  1  subtract request; present only when SUBTRACT_EN is defined.
REQ-009 busy  output  1  high while an operation is in progress, IDLE excluded.
REQ-010 done  output  1  one-cycle pulse; sum and cout are final.
REQ-011 sum  output  WIDTH  result register.
REQ-012 cout  output  1  carry out of the most significant nibble.

Function
REQ-013 The block SHALL compute a+b+cin over N=WIDTH/4 cycles with one shared 4-bit ripple adder, one nibble per cycle, least significant nibble first.
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE->RUN SHALL occur on a clock edge where start=1. On that edge the block SHALL latch a, b and cin, clear sum to 0, and set the nibble index to 0.
REQ-016 In RUN, each edge SHALL write nibble[i] of sum from the adder, load the carry register with the adder carry, and increment i.
REQ-017 RUN->DONE SHALL occur on the edge that writes nibble N-1. On that same edge cout SHALL load the final carry.
REQ-018 DONE->IDLE SHALL occur unconditionally on the next edge. done SHALL be 1 only in DONE.
REQ-019 busy SHALL be 1 in RUN and DONE.
REQ-020 Latency: done SHALL be high in the cycle following the N-th edge after start acceptance. Throughput SHALL be one operation per N+2 cycles.
REQ-021 start SHALL be ignored in RUN and DONE. Operand inputs SHALL be ignored except at the accept edge.
REQ-022 sum and cout SHALL hold their values from DONE until the next accepted start.
REQ-023 Carry SHALL propagate unchanged between nibbles. No saturation. The result wraps modulo 2^WIDTH, with overflow reported only on cout.

Reset
REQ-024 When rst=1 at an edge, state SHALL become IDLE and sum, cout, busy, done, the carry register and the index SHALL all be 0.
REQ-025 rst SHALL take priority over start and abort any operation in RUN or DONE; no done pulse SHALL follow.

Configuration
REQ-026 With SUBTRACT_EN defined and sub=1 at accept, the block SHALL compute a + ~b + 1, ignoring cin, and cout SHALL equal NOT borrow.
REQ-027 Without SUBTRACT_EN, the sub port and the inversion logic SHALL be absent, and behaviour SHALL be addition only.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration, the NIBBLE=4 constant, and the derived N/index-width function.
REQ-029 The adder SHALL be a separate sub-module, nibble_adder: 4-bit ripple of full-adder cells, ports a, b, cin, sum, cout, purely combinational.
REQ-030 The index register width SHALL be clog2(N).

Verification (WIDTH=16)
REQ-031 a=0x1234, b=0x4321, cin=0, start for one cycle -> busy from next cycle; done pulses after 4 edges; sum=0x5555, cout=0.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all 4 nibbles; sum=0x0000, cout=1; sum and cout held after done.
REQ-033 a=0x0000, b=0x0000, cin=1 -> sum=0x0001; then start re-asserted during RUN with a=0xAAAA -> ignored, result unchanged, one done pulse only.
REQ-034 a=0x00F0, b=0x0010, start; rst=1 on second RUN edge -> next cycle state IDLE, sum=0, cout=0, busy=0, no done; a new start then completes normally with sum=0x0100.
REQ-035 SUBTRACT_EN defined, sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
REQ-036 Back-to-back: start held high continuously -> operations accepted every N+2=6 cycles; each done pulse is exactly one cycle wide.
